uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 139 +++++++++++++
 tb/tb_uart_rx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled start/data/stop sampling.
// Emits a one-cycle rx_valid on a good frame, or frame_err on a low stop bit.
module uart_rx #(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int unsigned BAUD   = 9600,
    parameter int unsigned OVS    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rxdata,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned Div   = CLK_HZ / (BAUD * OVS);
    localparam int unsigned DivW  = ($clog2(Div) > 10) ? $clog2(Div) : 10;
    localparam int unsigned TickW = (OVS > 2) ? $clog2(OVS) : 1;

    localparam logic [DivW-1:0]  DivLast  = DivW'(Div - 1);
    localparam logic [TickW-1:0] HalfLast = TickW'(OVS / 2 - 1);
    localparam logic [TickW-1:0] FullLast = TickW'(OVS - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic              rx_meta_q, rx_s_q, rx_prev_q;
    logic [DivW-1:0]   div_cnt_q, div_cnt_d;
    logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        rxdata_q, rxdata_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              tick;

    // Free-running oversample tick, independent of frame alignment.
    assign tick      = (div_cnt_q == DivLast);
    assign div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rxdata_d    = rxdata_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            StIdle: begin
                tick_cnt_d = '0;
                bit_idx_d  = '0;
                // Only a genuine 1->0 transition starts a frame, not a held-low line.
                if (rx_prev_q && !rx_s_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    if (tick_cnt_q == HalfLast) begin
                        tick_cnt_d = '0;
                        bit_idx_d  = '0;
                        state_d    = rx_s_q ? StIdle : StData;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    if (tick_cnt_q == FullLast) begin
                        tick_cnt_d         = '0;
                        shift_d[bit_idx_q] = rx_s_q;
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_d = '0;
                            state_d   = StStop;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    if (tick_cnt_q == FullLast) begin
                        tick_cnt_d = '0;
                        state_d    = StIdle;
                        if (rx_s_q) begin
                            rxdata_d   = shift_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            div_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rxdata_q    <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            rx_prev_q   <= rx_s_q;
            div_cnt_q   <= div_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rxdata_q    <= rxdata_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rxdata    = rxdata_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx, run with a scaled clock (4 clocks per tick, 64 per bit).
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BitNs = 640;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rxdata;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    int last_valid_cyc = 0;
    int prev_valid_cyc = 0;
    logic [7:0] last_byte = 8'h00;

    uart_rx #(
        .CLK_HZ(614400),
        .BAUD  (9600),
        .OVS   (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rxdata   (rxdata),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt      = valid_cnt + 1;
            last_byte      = rxdata;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
        end
        if (frame_err) err_cnt = err_cnt + 1;
        if (rx_valid && frame_err) both_cnt = both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line is left at the stop-bit level on return.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int bit_ns);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop;
        #(bit_ns);
    endtask

    int t0, v0, e0, dly;
    logic [7:0] rb;

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_rxdata", 32'(rxdata), 32'h00);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #2;

        // Single frame with latency check against stop-bit mid-point (608 clocks).
        t0 = cyc;
        fork
            send_byte(8'h6C, 1'b1, BitNs);
            begin
                #3000;
                check("busy_mid_6c", 32'(busy), 32'd1);
            end
        join
        #(BitNs);
        check("cnt_6c", 32'(valid_cnt), 32'd1);
        check("data_6c", 32'(rxdata), 32'h6C);
        check("ferr_6c", 32'(err_cnt), 32'd0);
        dly = last_valid_cyc - t0;
        check("lat_6c", 32'(dly >= 606 && dly <= 614), 32'd1);
        check("idle_6c", 32'(busy), 32'd0);

        // Back-to-back frames with zero idle gap.
        v0 = valid_cnt;
        send_byte(8'h72, 1'b1, BitNs);
        check("data_72", 32'(rxdata), 32'h72);
        send_byte(8'h64, 1'b1, BitNs);
        #(BitNs);
        check("cnt_b2b", 32'(valid_cnt), 32'(v0 + 2));
        check("data_64", 32'(rxdata), 32'h64);
        dly = last_valid_cyc - prev_valid_cyc;
        check("gap_b2b", 32'(dly >= 636 && dly <= 644), 32'd1);
        check("ferr_b2b", 32'(err_cnt), 32'd0);

        // 3/16-bit low glitch must be rejected.
        v0 = valid_cnt;
        rx = 1'b0;
        #60;
        check("busy_glitch", 32'(busy), 32'd1);
        #60;
        rx = 1'b1;
        #(3 * BitNs);
        check("cnt_glitch", 32'(valid_cnt), 32'(v0));
        check("data_glitch", 32'(rxdata), 32'h64);
        check("idle_glitch", 32'(busy), 32'd0);
        check("ferr_glitch", 32'(err_cnt), 32'd0);

        // Bad stop bit, line held low without retriggering, then a good frame.
        v0 = valid_cnt;
        e0 = err_cnt;
        send_byte(8'hA5, 1'b0, BitNs);
        #(20 * BitNs);
        check("ferr_a5", 32'(err_cnt), 32'(e0 + 1));
        check("data_a5", 32'(rxdata), 32'h64);
        check("idle_low", 32'(busy), 32'd0);
        check("cnt_a5", 32'(valid_cnt), 32'(v0));
        rx = 1'b1;
        #(BitNs);
        send_byte(8'h3C, 1'b1, BitNs);
        #(BitNs);
        check("data_3c", 32'(rxdata), 32'h3C);
        check("cnt_3c", 32'(valid_cnt), 32'(v0 + 1));
        check("ferr_3c", 32'(err_cnt), 32'(e0 + 1));
        check("both", 32'(both_cnt), 32'd0);

        // Reset during data bit 4 of 8'hFF abandons the frame.
        v0 = valid_cnt;
        e0 = err_cnt;
        fork
            send_byte(8'hFF, 1'b1, BitNs);
            begin
                #(5 * BitNs + BitNs / 2);
                check("busy_ff", 32'(busy), 32'd1);
                rst_n = 1'b0;
                @(negedge clk);
                check("rst_mid_data", 32'(rxdata), 32'h00);
                check("rst_mid_busy", 32'(busy), 32'd0);
                check("rst_mid_valid", 32'(rx_valid), 32'd0);
                #(2 * BitNs);
                rst_n = 1'b1;
            end
        join
        #(BitNs);
        check("cnt_ff", 32'(valid_cnt), 32'(v0));
        check("ferr_ff", 32'(err_cnt), 32'(e0));
        check("data_ff", 32'(rxdata), 32'h00);
        send_byte(8'h0F, 1'b1, BitNs);
        #(BitNs);
        check("data_0f", 32'(rxdata), 32'h0F);
        check("cnt_0f", 32'(valid_cnt), 32'(v0 + 1));

        // Random bytes with about +/-2% baud error, back-to-back.
        v0 = valid_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 48; i++) begin
            rb = 8'($urandom);
            send_byte(rb, 1'b1, (i % 2 == 0) ? 627 : 653);
            check("rand_data", 32'(rxdata), 32'(rb));
        end
        #(BitNs);
        check("rand_cnt", 32'(valid_cnt), 32'(v0 + 48));
        check("rand_ferr", 32'(err_cnt), 32'(e0));
        check("rand_both", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
